// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RISC-V core: sequences each instruction
// through its states and drives the datapath mux selects, write enables,
// ALU operation and immediate format.
module multicycle_ctrl #(
    parameter int SEL_WIDTH      = 2,
    parameter int ALU_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                op,
    input  logic [2:0]                funct3,
    input  logic                      funct7b5,
    input  logic                      zero,
    output logic                      pc_write,
    output logic                      adr_src,
    output logic                      mem_write,
    output logic                      ir_write,
    output logic                      reg_write,
    output logic [SEL_WIDTH-1:0]      result_src,
    output logic [SEL_WIDTH-1:0]      alu_src_a,
    output logic [SEL_WIDTH-1:0]      alu_src_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic [1:0]                imm_src,
    output logic                      illegal_instr
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BEQ
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    state_t     state;
    state_t     state_next;
    aluop_t     aluop;
    logic [1:0] res_sel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [2:0] alu_ctl;
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       reg_w;
    logic       illegal;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore outputs (BEQ's pc_write is the lone use of zero).
    always_comb begin
        state_next = S_FETCH;
        aluop      = ALUOP_ADD;
        res_sel    = 2'd0;
        a_sel      = 2'd0;
        b_sel      = 2'd0;
        adr_src    = 1'b0;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_w       = 1'b1;
                pc_w       = 1'b1;
                b_sel      = 2'd2;
                res_sel    = 2'd2;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                a_sel = 2'd1;
                b_sel = 2'd1;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                a_sel      = 2'd2;
                b_sel      = 2'd1;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                res_sel    = 2'd1;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                a_sel      = 2'd2;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                a_sel      = 2'd2;
                b_sel      = 2'd1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_JAL: begin
                a_sel      = 2'd1;
                b_sel      = 2'd2;
                pc_w       = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                a_sel      = 2'd2;
                aluop      = ALUOP_SUB;
                pc_w       = zero;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ALU operation decode from aluop, funct3, funct7[5] and op[5].
    always_comb begin
        alu_ctl = 3'd0;
        case (aluop)
            ALUOP_SUB: alu_ctl = 3'd1;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctl = (op[5] & funct7b5) ? 3'd1 : 3'd0;
                    3'b010:  alu_ctl = 3'd5;
                    3'b110:  alu_ctl = 3'd3;
                    3'b111:  alu_ctl = 3'd2;
                    default: alu_ctl = 3'd0;
                endcase
            end
            default: alu_ctl = 3'd0;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'd1;
            OP_BEQ:  imm_src = 2'd2;
            OP_JAL:  imm_src = 2'd3;
            default: imm_src = 2'd0;
        endcase
    end

    // Reset blocks every write enable and the illegal pulse combinationally.
    assign pc_write      = pc_w & ~rst;
    assign mem_write     = mem_w & ~rst;
    assign ir_write      = ir_w & ~rst;
    assign reg_write     = reg_w & ~rst;
    assign illegal_instr = illegal & ~rst;

    assign result_src  = SEL_WIDTH'(res_sel);
    assign alu_src_a   = SEL_WIDTH'(a_sel);
    assign alu_src_b   = SEL_WIDTH'(b_sel);
    assign alu_control = ALU_CTRL_WIDTH'(alu_ctl);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its states and checks every output against hand-computed values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       illegal_instr;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(
        .SEL_WIDTH      (2),
        .ALU_CTRL_WIDTH (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs. Field order: pw as mw iw rw rs sa sb ac is il
    task automatic chk(input string tag,
                       input logic pw, input logic as, input logic mw,
                       input logic iw, input logic rw,
                       input logic [1:0] rs, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [2:0] ac,
                       input logic [1:0] is, input logic il);
        logic [16:0] obs;
        logic [16:0] exp;
        #1;
        obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr};
        exp = {pw, as, mw, iw, rw, rs, sa, sb, ac, is, il};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        op       = 7'b0000011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        tick();
        tick();
        // In reset: FETCH selects, but all writes held low
        chk("reset_hold",   0,0,0,0,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);

        // Reach MEMREAD with lw, then reset there for two cycles
        rst = 1'b0;
        chk("lw0_fetch",    1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);
        tick();
        chk("lw0_decode",   0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("lw0_memadr",   0,0,0,0,0, 2'd0,2'd2,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("lw0_memread",  0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0, 2'd0, 0);
        rst = 1'b1;
        tick();
        chk("rst_mid1",     0,0,0,0,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);
        tick();
        chk("rst_mid2",     0,0,0,0,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);
        rst = 1'b0;
        chk("rst_release",  1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);

        // lw: 5 cycles, MEMWB writes from Data
        tick();
        chk("lw_decode",    0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("lw_memadr",    0,0,0,0,0, 2'd0,2'd2,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("lw_memread",   0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0, 2'd0, 0);
        tick();
        chk("lw_memwb",     0,0,0,0,1, 2'd1,2'd0,2'd0,3'd0, 2'd0, 0);
        tick();

        // sw: write in cycle 4 only
        op = 7'b0100011;
        chk("sw_fetch",     1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd1, 0);
        tick();
        chk("sw_decode",    0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd1, 0);
        tick();
        chk("sw_memadr",    0,0,0,0,0, 2'd0,2'd2,2'd1,3'd0, 2'd1, 0);
        tick();
        chk("sw_memwrite",  0,1,1,0,0, 2'd0,2'd0,2'd0,3'd0, 2'd1, 0);
        tick();

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        chk("rsub_fetch",   1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);
        tick();
        chk("rsub_decode",  0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("rsub_execr",   0,0,0,0,0, 2'd0,2'd2,2'd0,3'd1, 2'd0, 0);
        tick();
        chk("rsub_aluwb",   0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0, 2'd0, 0);
        tick();

        // R-type slt
        funct3 = 3'b010; funct7b5 = 1'b0;
        tick();
        tick();
        chk("rslt_execr",   0,0,0,0,0, 2'd0,2'd2,2'd0,3'd5, 2'd0, 0);
        tick();
        chk("rslt_aluwb",   0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0, 2'd0, 0);
        tick();

        // I-type with funct3=000, bit30 set: op[5]=0 so still add
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick();
        tick();
        chk("iadd_execi",   0,0,0,0,0, 2'd0,2'd2,2'd1,3'd0, 2'd0, 0);
        funct3 = 3'b110;
        chk("ior_execi",    0,0,0,0,0, 2'd0,2'd2,2'd1,3'd3, 2'd0, 0);
        funct3 = 3'b111;
        chk("iand_execi",   0,0,0,0,0, 2'd0,2'd2,2'd1,3'd2, 2'd0, 0);
        funct3 = 3'b001;
        chk("ioth_execi",   0,0,0,0,0, 2'd0,2'd2,2'd1,3'd0, 2'd0, 0);
        tick();
        chk("i_aluwb",      0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0, 2'd0, 0);
        tick();

        // beq taken
        op = 7'b1100011; zero = 1'b1;
        chk("beq1_fetch",   1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd2, 0);
        tick();
        chk("beq1_decode",  0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd2, 0);
        tick();
        chk("beq1_beq",     1,0,0,0,0, 2'd0,2'd2,2'd0,3'd1, 2'd2, 0);
        tick();
        // beq not taken
        zero = 1'b0;
        chk("beq0_fetch",   1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd2, 0);
        tick();
        tick();
        chk("beq0_beq",     0,0,0,0,0, 2'd0,2'd2,2'd0,3'd1, 2'd2, 0);
        tick();
        chk("beq0_refetch", 1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd2, 0);

        // jal
        op = 7'b1101111;
        tick();
        chk("jal_decode",   0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd3, 0);
        tick();
        chk("jal_jal",      1,0,0,0,0, 2'd0,2'd1,2'd2,3'd0, 2'd3, 0);
        tick();
        chk("jal_aluwb",    0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0, 2'd3, 0);
        tick();

        // Illegal opcode: pulse in DECODE, then straight back to FETCH
        op = 7'b1111111;
        chk("ill_fetch",    1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);
        tick();
        chk("ill_decode",   0,0,0,0,0, 2'd0,2'd1,2'd1,3'd0, 2'd0, 1);
        tick();
        chk("ill_refetch",  1,0,0,1,0, 2'd2,2'd0,2'd2,3'd0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM of the multicycle RISC-V core.
- Sits directly upstream of the datapath muxes (PC/OldPC/rs1 operand-A mux, rs2/imm/4 operand-B mux, ALUOut/Data/ALUResult result mux, PC/ALUOut address mux) and drives their select lines.
- Also drives the datapath write enables, the ALU operation and the immediate format.
- Decodes opcode, funct3 and funct7[5] from the instruction register, and the ALU zero flag.

Parameters:
- SEL_WIDTH, 2, width of each 3-input mux select (alu_src_a, alu_src_b, result_src); must be ≥2; bits above bit 1 are always 0.
- ALU_CTRL_WIDTH, 3, width of alu_control; must be ≥3; upper bits are 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode from the instruction register.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- zero  in  1  ALU result == 0.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction/OldPC register enable.
- reg_write  out  1  register file write enable.
- result_src  out  SEL_WIDTH  0 = ALUOut, 1 = Data, 2 = ALUResult.
- alu_src_a  out  SEL_WIDTH  0 = PC, 1 = OldPC, 2 = rs1.
- alu_src_b  out  SEL_WIDTH  0 = rs2, 1 = imm, 2 = const 4.
- alu_control  out  ALU_CTRL_WIDTH  0 add, 1 sub, 2 and, 3 or, 5 slt.
- imm_src  out  2  0 I-type, 1 S-type, 2 B-type, 3 J-type.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BEQ.
- Reset:
  - rst high at a rising edge → state = FETCH.
  - While rst is high, pc_write, ir_write, reg_write and mem_write are forced 0 and illegal_instr is 0.
  - Reset has priority in any state; an instruction in flight is abandoned with no further writes.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECR (R), EXECI (I-ALU), JAL (jal), BEQ (beq).
  - DECODE→FETCH on any other opcode, with illegal_instr=1 during that DECODE cycle only.
  - MEMADR→MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR, EXECI and JAL→ALUWB; ALUWB→FETCH.
  - BEQ→FETCH.
- Cycles per instruction: lw 5; sw, R, I and jal 4; beq 3.
- Moore outputs per state (anything not listed is 0):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=0, alu_src_b=2, aluop=add, result_src=2, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=1, aluop=add.
  - MEMADR: alu_src_a=2, alu_src_b=1, aluop=add.
  - MEMREAD: result_src=0, adr_src=1.
  - MEMWB: result_src=1, reg_write=1.
  - MEMWRITE: result_src=0, adr_src=1, mem_write=1.
  - EXECR: alu_src_a=2, alu_src_b=0, aluop=funct.
  - EXECI: alu_src_a=2, alu_src_b=1, aluop=funct.
  - JAL: alu_src_a=1, alu_src_b=2, aluop=add, result_src=0, pc_write=1.
  - ALUWB: result_src=0, reg_write=1.
  - BEQ: alu_src_a=2, alu_src_b=0, aluop=sub, result_src=0, pc_write=zero. This is the only combinational dependency on zero.
- ALU decode (combinational):
  - aluop=add → 0; aluop=sub → 1.
  - aluop=funct, funct3=000 → 1 if op[5]&funct7b5, else 0.
  - aluop=funct, funct3=010 → 5; 110 → 3; 111 → 2; any other funct3 → 0 (add).
- imm_src (combinational on op, every state):
  - sw → 1; beq → 2; jal → 3; all other opcodes → 0.
- No more than one of mem_write/reg_write is high in any cycle; ir_write is high only in FETCH.
- The select outputs never take the value 3.

Test Plan:
- Reset: rst=1 for 2 cycles in MEMREAD, then release → next cycle is FETCH with ir_write=1, pc_write=1, alu_src_b=2; reg_write stays 0 throughout.
- lw: op=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. MEMWB shows reg_write=1, result_src=1; imm_src=0 throughout; 5 cycles total.
- sw: op=0100011 → mem_write=1 only in cycle 4 with adr_src=1; imm_src=1; reg_write never 1.
- R-type sub/slt: op=0110011, funct3=000, funct7b5=1 → alu_control=1 in EXECR. Then funct3=010 → alu_control=5; ALUWB reg_write=1.
- beq: zero=1 → pc_write=1 in the BEQ cycle; repeat with zero=0 → pc_write=0. Both return to FETCH after 3 cycles; imm_src=2.
- Illegal: op=1111111 → illegal_instr=1 for exactly the DECODE cycle, next state FETCH, no write enable asserted.
